// File: rtl/pseq_pkg.sv
// Shared constants, state type and helpers for the period sequencer.
// Optional pass counter is enabled with the PSEQ_PASS_CNT_EN macro.
package pseq_pkg;

  localparam int PERIOD_W = 5;
  localparam int NUM_SLOTS = 3;
  localparam int CTRL_W = 3;

  localparam logic [1:0] ADDR_P0   = 2'd0;
  localparam logic [1:0] ADDR_P1   = 2'd1;
  localparam logic [1:0] ADDR_P2   = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam int CTRL_LAST_LO = 0;
  localparam int CTRL_LAST_HI = 1;
  localparam int CTRL_LOOP    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pseq_state_e;

  // A last_slot code of 3 has no matching slot, so it runs as slot 2.
  function automatic logic [1:0] effLastSlot(input logic [1:0] raw);
    return (raw == 2'd3) ? 2'd2 : raw;
  endfunction

  function automatic logic [PERIOD_W-1:0] periodAt(
    input logic [NUM_SLOTS-1:0][PERIOD_W-1:0] periods,
    input logic [1:0]                         idx
  );
    logic [PERIOD_W-1:0] sel;
    case (idx)
      2'd0:    sel = periods[0];
      2'd1:    sel = periods[1];
      default: sel = periods[2];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pseq_regfile.sv
// Write-only register file: three period slots plus a control word whose
// writes are dropped while a sequence is running.
module pseq_regfile
  import pseq_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_wrEn,
  input  logic [1:0]                           i_wrAddr,
  input  logic [PERIOD_W-1:0]                  i_wrData,
  input  logic                                 i_busy,
  output logic [NUM_SLOTS-1:0][PERIOD_W-1:0]   o_periods,
  output logic [1:0]                           o_lastSlot,
  output logic                                 o_loop
);

  logic [NUM_SLOTS-1:0][PERIOD_W-1:0] r_periods;
  logic [CTRL_W-1:0]                  r_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_periods <= '0;
      r_ctrl    <= '0;
    end else if (i_wrEn) begin
      case (i_wrAddr)
        ADDR_P0: r_periods[0] <= i_wrData;
        ADDR_P1: r_periods[1] <= i_wrData;
        ADDR_P2: r_periods[2] <= i_wrData;
        default: begin
          if (!i_busy) begin
            r_ctrl <= i_wrData[CTRL_W-1:0];
          end
        end
      endcase
    end
  end

  assign o_periods  = r_periods;
  assign o_lastSlot = effLastSlot(r_ctrl[CTRL_LAST_HI:CTRL_LAST_LO]);
  assign o_loop     = r_ctrl[CTRL_LOOP];

endmodule

// File: rtl/period_sequencer.sv
// Steps a downstream terminal-count counter through up to three programmed
// periods. Optional pass counter: define PSEQ_PASS_CNT_EN.
module period_sequencer
  import pseq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [1:0]          wr_addr,
  input  logic [PERIOD_W-1:0] wr_data,
  input  logic                start,
  input  logic                stop,
  input  logic                cout,
  output logic [PERIOD_W-1:0] value,
  output logic                cnt_en,
  output logic [1:0]          slot,
  output logic                busy,
  output logic                done
`ifdef PSEQ_PASS_CNT_EN
  ,output logic [3:0]         pass_cnt
`endif
);

  pseq_state_e r_state;
  pseq_state_e w_nextState;

  logic [1:0]          r_slot;
  logic [1:0]          w_nextSlot;
  logic [PERIOD_W-1:0] r_value;
  logic [PERIOD_W-1:0] w_nextValue;
  logic                r_stopReq;
  logic                w_nextStopReq;
  logic                r_done;
  logic                w_nextDone;
  logic [1:0]          r_runLast;
  logic [1:0]          w_nextRunLast;
  logic                r_runLoop;
  logic                w_nextRunLoop;

  logic [NUM_SLOTS-1:0][PERIOD_W-1:0] w_periods;
  logic [1:0]                         w_lastSlot;
  logic                               w_loop;
  logic                               w_busy;
  logic                               w_stopNow;
  logic [1:0]                         w_slotPlus1;

  pseq_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wrEn     (wr_en),
    .i_wrAddr   (wr_addr),
    .i_wrData   (wr_data),
    .i_busy     (w_busy),
    .o_periods  (w_periods),
    .o_lastSlot (w_lastSlot),
    .o_loop     (w_loop)
  );

  assign w_busy      = (r_state == RUN);
  assign w_stopNow   = r_stopReq | stop;
  assign w_slotPlus1 = r_slot + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_slot    <= '0;
      r_value   <= '0;
      r_stopReq <= 1'b0;
      r_done    <= 1'b0;
      r_runLast <= '0;
      r_runLoop <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_slot    <= w_nextSlot;
      r_value   <= w_nextValue;
      r_stopReq <= w_nextStopReq;
      r_done    <= w_nextDone;
      r_runLast <= w_nextRunLast;
      r_runLoop <= w_nextRunLoop;
    end
  end

  // Control is snapshotted at start so a same-cycle control write only
  // affects the following run.
  always_comb begin
    w_nextState   = r_state;
    w_nextSlot    = r_slot;
    w_nextValue   = r_value;
    w_nextStopReq = r_stopReq;
    w_nextDone    = 1'b0;
    w_nextRunLast = r_runLast;
    w_nextRunLoop = r_runLoop;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState   = RUN;
          w_nextSlot    = 2'd0;
          w_nextValue   = w_periods[0];
          w_nextStopReq = 1'b0;
          w_nextRunLast = w_lastSlot;
          w_nextRunLoop = w_loop;
        end
      end
      RUN: begin
        if (stop) begin
          w_nextStopReq = 1'b1;
        end
        if (cout) begin
          if (!w_stopNow && (r_slot < r_runLast)) begin
            w_nextSlot  = w_slotPlus1;
            w_nextValue = periodAt(w_periods, w_slotPlus1);
          end else if (!w_stopNow && r_runLoop) begin
            w_nextSlot  = 2'd0;
            w_nextValue = w_periods[0];
          end else begin
            w_nextState = IDLE;
            w_nextDone  = 1'b1;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

`ifdef PSEQ_PASS_CNT_EN
  logic [3:0] r_passCnt;
  logic       w_passClr;
  logic       w_passInc;

  assign w_passClr = (r_state == IDLE) && start;
  assign w_passInc = (r_state == RUN) && cout && (r_slot == r_runLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_passCnt <= '0;
    end else if (w_passClr) begin
      r_passCnt <= '0;
    end else if (w_passInc) begin
      r_passCnt <= r_passCnt + 4'd1;
    end
  end

  assign pass_cnt = r_passCnt;
`endif

  // Dropping the enable on cout lets the counter clear cout with its count
  // parked at 0, giving one turnaround cycle per slot.
  assign cnt_en = w_busy & ~cout;
  assign busy   = w_busy;
  assign value  = r_value;
  assign slot   = r_slot;
  assign done   = r_done;

endmodule

// File: tb/tb_period_sequencer.sv
// Directed self-checking bench for period_sequencer driving a behavioural
// model of the downstream 5-bit terminal-count counter.
module tb_period_sequencer;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [4:0] wr_data;
  logic       start;
  logic       stop;
  logic       cout;
  logic [4:0] value;
  logic       cnt_en;
  logic [1:0] slot;
  logic       busy;
  logic       done;
`ifdef PSEQ_PASS_CNT_EN
  logic [3:0] passCnt;
`endif

  logic [4:0] cntReg;
  int checks;
  int failures;

  period_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .stop    (stop),
    .cout    (cout),
    .value   (value),
    .cnt_en  (cnt_en),
    .slot    (slot),
    .busy    (busy),
    .done    (done)
`ifdef PSEQ_PASS_CNT_EN
    ,.pass_cnt (passCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream counter: wraps to 0 and flags cout after reaching value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntReg <= '0;
      cout   <= 1'b0;
    end else if (cnt_en) begin
      if (cntReg == value) begin
        cntReg <= '0;
        cout   <= 1'b1;
      end else begin
        cntReg <= cntReg + 5'd1;
        cout   <= 1'b0;
      end
    end else begin
      cout <= 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] addr, input logic [4:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic startSeq(input logic pWr, input logic [1:0] pAddr, input logic [4:0] pData);
    start   = 1'b1;
    wr_en   = pWr;
    wr_addr = pAddr;
    wr_data = pData;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  // Called on the first cycle of a slot; returns on the first cycle after its cout.
  task automatic runSlot(input string tag, input logic [4:0] expVal, input logic [1:0] expSlot,
                         input int expEn, input logic pWr, input logic [1:0] pAddr,
                         input logic [4:0] pData, input logic pStop, input logic pStart);
    int enCycles = 0;
    int n = 0;
    logic seen = 1'b0;
    checkOutput({tag, ".value"}, value, expVal);
    checkOutput({tag, ".slot"}, slot, expSlot);
    checkOutput({tag, ".busy"}, busy, 1);
    wr_en   = pWr;
    wr_addr = pAddr;
    wr_data = pData;
    stop    = pStop;
    start   = pStart;
    while (n < 64) begin
      if (cout) begin
        seen = 1'b1;
        break;
      end
      if (cnt_en) enCycles++;
      @(negedge clk);
      wr_en = 1'b0;
      stop  = 1'b0;
      start = 1'b0;
      n++;
    end
    wr_en = 1'b0;
    stop  = 1'b0;
    start = 1'b0;
    checkOutput({tag, ".coutSeen"}, seen, 1);
    checkOutput({tag, ".enCycles"}, enCycles, expEn);
    checkOutput({tag, ".enAtCout"}, cnt_en, 0);
    @(negedge clk);
  endtask

  task automatic finishCheck(input string tag);
    checkOutput({tag, ".done"}, done, 1);
    checkOutput({tag, ".busyEnd"}, busy, 0);
    checkOutput({tag, ".enEnd"}, cnt_en, 0);
    @(negedge clk);
    checkOutput({tag, ".donePulse"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    start    = 1'b0;
    stop     = 1'b0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("rst.value", value, 0);
    checkOutput("rst.cnt_en", cnt_en, 0);
    checkOutput("rst.slot", slot, 0);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.done", done, 0);
`ifdef PSEQ_PASS_CNT_EN
    checkOutput("rst.passCnt", passCnt, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Single pass over periods {2,4,1}
    applyStimulus(2'd0, 5'd2);
    applyStimulus(2'd1, 5'd4);
    applyStimulus(2'd2, 5'd1);
    applyStimulus(2'd3, 5'b00010);
    startSeq(1'b0, 2'd0, 5'd0);
    runSlot("t1s0", 5'd2, 2'd0, 3, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    runSlot("t1s1", 5'd4, 2'd1, 5, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    runSlot("t1s2", 5'd1, 2'd2, 2, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    finishCheck("t1");
`ifdef PSEQ_PASS_CNT_EN
    checkOutput("t1.passCnt", passCnt, 1);
`endif

    // Looping over slots 0/1 with busy-time writes, ignored start, then stop
    applyStimulus(2'd3, 5'b00101);
    applyStimulus(2'd0, 5'd0);
    applyStimulus(2'd1, 5'd3);
    startSeq(1'b0, 2'd0, 5'd0);
    runSlot("t2p1s0", 5'd0, 2'd0, 1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    runSlot("t2p1s1", 5'd3, 2'd1, 4, 1'b1, 2'd3, 5'b00010, 1'b0, 1'b0);
    runSlot("t2p2s0", 5'd0, 2'd0, 1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1);
`ifdef PSEQ_PASS_CNT_EN
    checkOutput("t2.passCnt1", passCnt, 1);
`endif
    runSlot("t2p2s1", 5'd3, 2'd1, 4, 1'b1, 2'd1, 5'd7, 1'b0, 1'b0);
    runSlot("t2p3s0", 5'd0, 2'd0, 1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    runSlot("t2p3s1", 5'd7, 2'd1, 8, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    runSlot("t2p4s0", 5'd0, 2'd0, 1, 1'b0, 2'd0, 5'd0, 1'b1, 1'b0);
    finishCheck("t2");
    checkOutput("t2.slotEnd", slot, 0);
`ifdef PSEQ_PASS_CNT_EN
    checkOutput("t2.passCnt", passCnt, 3);
`endif

    // Same-cycle ctrl write with start: first run keeps loop=1 last=1
    startSeq(1'b1, 2'd3, 5'b00000);
    runSlot("t3as0", 5'd0, 2'd0, 1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    runSlot("t3as1", 5'd7, 2'd1, 8, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    runSlot("t3as0b", 5'd0, 2'd0, 1, 1'b0, 2'd0, 5'd0, 1'b1, 1'b0);
    finishCheck("t3a");

    // New ctrl (last=0) now active; same-cycle period write loads old value
    startSeq(1'b1, 2'd0, 5'd5);
    runSlot("t3bs0", 5'd0, 2'd0, 1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    finishCheck("t3b");
`ifdef PSEQ_PASS_CNT_EN
    checkOutput("t3b.passCnt", passCnt, 1);
`endif

    // last_slot code 3 runs through slot 2 and ends
    applyStimulus(2'd3, 5'b00011);
    startSeq(1'b0, 2'd0, 5'd0);
    runSlot("t4s0", 5'd5, 2'd0, 6, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    runSlot("t4s1", 5'd7, 2'd1, 8, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    runSlot("t4s2", 5'd1, 2'd2, 2, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    finishCheck("t4");

    // Asynchronous reset in the middle of slot 1
    startSeq(1'b0, 2'd0, 5'd0);
    runSlot("t5s0", 5'd5, 2'd0, 6, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("t5.slot1", slot, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5.value", value, 0);
    checkOutput("t5.slot", slot, 0);
    checkOutput("t5.busy", busy, 0);
    checkOutput("t5.cnt_en", cnt_en, 0);
    checkOutput("t5.done", done, 0);
`ifdef PSEQ_PASS_CNT_EN
    checkOutput("t5.passCnt", passCnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t5.noDone", done, 0);
    end

    // Registers were cleared: period 0, single slot, no loop
    startSeq(1'b0, 2'd0, 5'd0);
    runSlot("t5post", 5'd0, 2'd0, 1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    finishCheck("t5post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/period_sequencer.md
# period_sequencer

Programmable period sequencer sitting directly upstream of the 5-bit terminal-count `counter` stage. It holds up to three 5-bit period entries plus a control word written through a small address/data port, then drives the counter's `value` and `en` inputs slot by slot, advancing on each `cout`. It runs one pass (or loops), signals completion with a one-cycle `done` pulse, and supports a graceful stop at the end of the current slot.

## Interface
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `wr_en` input 1: write strobe
- `wr_addr` input 2: 0/1/2 = period slot 0/1/2, 3 = control word
- `wr_data` input 5: write data; ctrl: [1:0] last_slot, [2] loop, [4:3] reserved (write ignored, read 0)
- `start` input 1: begin sequence (accepted in IDLE only)
- `stop` input 1: request end after current slot
- `cout` input 1: terminal-count flag from downstream counter
- `value` output 5: period presented to counter (registered shadow)
- `cnt_en` output 1: counter enable, combinational
- `slot` output 2: active slot index
- `busy` output 1: high in RUN
- `done` output 1: one-cycle completion pulse
- `pass_cnt` output 4: completed passes (only with `PSEQ_PASS_CNT_EN`)

## Operation
- Storage: period[0..2] (5 bit), ctrl (3 bit). Reset: all 0.
- Writes always accepted to period slots; take effect at the next slot load, never mid-slot. Ctrl writes ignored while busy.
- last_slot = 3 is treated as 2.
- States: IDLE, RUN.
- IDLE: `start` → RUN; slot←0; value←period[0]; stop_req←0. Otherwise hold.
- RUN: `cnt_en = !cout`. On `cout`=1:
  - slot < last_slot and no stop_req → slot+1, value←period[slot+1], stay RUN.
  - slot == last_slot, loop=1, no stop_req → slot←0, value←period[0], stay RUN (pass complete).
  - else → IDLE, `done`=1 for one cycle.
- `stop` in RUN sets sticky stop_req; ignored in IDLE.
- `start` while busy ignored.
- Dropping `cnt_en` combinationally when `cout` is high makes the counter clear `cout` at that edge with its count held at 0, so each slot lasts value+1 enabled cycles plus one turnaround cycle.

## Timing
- Reset values: value=0, cnt_en=0, slot=0, busy=0, done=0, pass_cnt=0.
- `start` at edge N → busy=1, cnt_en=1, value=period[0] from cycle N+1.
- Slot with period P: `cout` high P+1 cycles after first enabled cycle; next slot's value visible the cycle after `cout`.
- `done` asserted the cycle after the final `cout`, coincident with busy=0.
- Same-cycle write and `start`: load uses the pre-write contents.
- Same-cycle `stop` and `cout`: stop honored at that boundary (ends now).
- Reset mid-sequence: immediate return to IDLE, all registers cleared; no `done`.

## Configuration
- `PSEQ_PASS_CNT_EN` defined: `pass_cnt` port present; increments on every completed pass, including the terminal one; wraps 15→0; cleared on accepted `start`.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Package `pseq_pkg`: state enum (IDLE, RUN), address constants ADDR_P0/ADDR_P1/ADDR_P2/ADDR_CTRL, ctrl bit positions, width constant PERIOD_W=5.
- One sub-module: `pseq_regfile` (write decode, period and ctrl storage, busy-gated ctrl write). FSM and shadow `value` live in the top.

## Test plan
- Write period{2,4,1}, ctrl{last_slot=2, loop=0}, start → value sequence 2,4,1; slot lengths 3/5/2 enabled cycles; single `done` pulse; busy=0 after.
- Ctrl loop=1, last_slot=1, periods{0,3} → slots alternate 0,1,0,1…; pass_cnt increments each pass; `stop` during slot 0 ends after slot 0 with `done`.
- Write period[1]=7 while slot 1 is active → current slot unchanged; next pass uses 7.
- Ctrl write while busy → ignored; `start` while busy → ignored.
- `start` with same-cycle ctrl write → first run uses old ctrl.
- `rst_n` low mid-slot 1 → all outputs 0 asynchronously; no `done`.
- last_slot=3 → behaves as last_slot=2.
